// File: rtl/frat_rename_if.sv
`default_nettype none
// ============================================================================
// Module   : frat_rename_if
// Brief    : Decode / free-list / ROB / RRAT bundle for the FRAT rename stage.
// Revision : 1.0 - initial release
// ============================================================================
interface frat_rename_if #(
  parameter int AW = 5,
  parameter int PW = 6
);
  logic          valid_IN_DECODE;
  logic [AW-1:0] src1_IN_DECODE;
  logic [AW-1:0] src2_IN_DECODE;
  logic [AW-1:0] dest_IN_DECODE;
  logic          wdest_IN_DECODE;
  logic          ready_OUT_DECODE;
  logic [PW-1:0] free_register_IN_FREELIST;
  logic          free_valid_IN_FREELIST;
  logic          enable_OUT_FREELIST;
  logic          valid_OUT_ROB;
  logic          ready_IN_ROB;
  logic [PW-1:0] psrc1_OUT_ROB;
  logic [PW-1:0] psrc2_OUT_ROB;
  logic [PW-1:0] pdest_OUT_ROB;
  logic [PW-1:0] old_pdest_OUT_ROB;
  logic          wdest_OUT_ROB;
  logic          flush_IN_ROB;
  logic [AW-1:0] rrat_addr_OUT_RRAT;
  logic [PW-1:0] rrat_data_IN_RRAT;
  logic          recovering_OUT;

  // Rename stage side
  modport slave (
    input  valid_IN_DECODE, src1_IN_DECODE, src2_IN_DECODE, dest_IN_DECODE,
           wdest_IN_DECODE, free_register_IN_FREELIST, free_valid_IN_FREELIST,
           ready_IN_ROB, flush_IN_ROB, rrat_data_IN_RRAT,
    output ready_OUT_DECODE, enable_OUT_FREELIST, valid_OUT_ROB, psrc1_OUT_ROB,
           psrc2_OUT_ROB, pdest_OUT_ROB, old_pdest_OUT_ROB, wdest_OUT_ROB,
           rrat_addr_OUT_RRAT, recovering_OUT
  );

  // Surrounding pipeline side
  modport master (
    output valid_IN_DECODE, src1_IN_DECODE, src2_IN_DECODE, dest_IN_DECODE,
           wdest_IN_DECODE, free_register_IN_FREELIST, free_valid_IN_FREELIST,
           ready_IN_ROB, flush_IN_ROB, rrat_data_IN_RRAT,
    input  ready_OUT_DECODE, enable_OUT_FREELIST, valid_OUT_ROB, psrc1_OUT_ROB,
           psrc2_OUT_ROB, pdest_OUT_ROB, old_pdest_OUT_ROB, wdest_OUT_ROB,
           rrat_addr_OUT_RRAT, recovering_OUT
  );
endinterface
`default_nettype wire

// File: rtl/frat_rename.sv
`default_nettype none
// ============================================================================
// Module   : frat_rename
// Brief    : Front-end register alias table and rename stage with RRAT recovery.
// Revision : 1.0 - initial release
// ============================================================================
module frat_rename #(
  parameter int ARCH_REGS = 32,
  parameter int AW        = 5,
  parameter int PW        = 6
) (
  input  logic          CLK,
  input  logic          RESET_N,
  frat_rename_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_POP_WAIT = 2'd1,
    ST_RECOVER  = 2'd2
  } state_t;

  localparam logic [AW-1:0] c_last_idx = AW'(ARCH_REGS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;

  logic          w_need_dest;
  logic          w_ready;
  logic          w_accept;
  logic          w_rename;
  logic          w_recover_wr;
  logic [PW-1:0] w_map [ARCH_REGS];

  logic          r_valid;
  logic          r_pop;
  logic [PW-1:0] r_psrc1;
  logic [PW-1:0] r_psrc2;
  logic [PW-1:0] r_pdest;
  logic [PW-1:0] r_old_pdest;
  logic          r_wdest;

  always_comb begin
    w_need_dest  = bus.wdest_IN_DECODE && (bus.dest_IN_DECODE != '0);
    w_ready      = (r_state == ST_RUN) && !bus.flush_IN_ROB
                   && (!r_valid || bus.ready_IN_ROB)
                   && (!w_need_dest || bus.free_valid_IN_FREELIST);
    w_accept     = bus.valid_IN_DECODE && w_ready;
    w_rename     = w_accept && w_need_dest;
    w_recover_wr = (r_state == ST_RECOVER) && !bus.flush_IN_ROB;
  end

  // Flush overrides every state and restarts the RRAT walk from entry 0
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (bus.flush_IN_ROB) begin
      w_state_nxt = ST_RECOVER;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_rename) w_state_nxt = ST_POP_WAIT;
        end
        ST_POP_WAIT: begin
          w_state_nxt = ST_RUN;
        end
        ST_RECOVER: begin
          w_idx_nxt = r_idx + AW'(1);
          if (r_idx == c_last_idx) begin
            w_state_nxt = ST_RUN;
            w_idx_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_RUN;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Entry 0 is $zero and is never remapped, not even by recovery
  for (genvar gi = 0; gi < ARCH_REGS; gi++) begin : g_map
    if (gi == 0) begin : g_zero
      assign w_map[gi] = '0;
    end else begin : g_entry
      logic [PW-1:0] r_entry;
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_entry <= PW'(gi);
        end else if (w_recover_wr && (r_idx == AW'(gi))) begin
          r_entry <= bus.rrat_data_IN_RRAT;
        end else if (w_rename && (bus.dest_IN_DECODE == AW'(gi))) begin
          r_entry <= bus.free_register_IN_FREELIST;
        end
      end
      assign w_map[gi] = r_entry;
    end
  end

  // Sources and old_pdest read the map before this instruction's own update
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid     <= 1'b0;
      r_pop       <= 1'b0;
      r_psrc1     <= '0;
      r_psrc2     <= '0;
      r_pdest     <= '0;
      r_old_pdest <= '0;
      r_wdest     <= 1'b0;
    end else begin
      r_pop <= w_rename;
      if (bus.flush_IN_ROB) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid     <= 1'b1;
        r_psrc1     <= w_map[bus.src1_IN_DECODE];
        r_psrc2     <= w_map[bus.src2_IN_DECODE];
        r_pdest     <= w_need_dest ? bus.free_register_IN_FREELIST : '0;
        r_old_pdest <= w_need_dest ? w_map[bus.dest_IN_DECODE] : '0;
        r_wdest     <= w_need_dest;
      end else if (bus.ready_IN_ROB) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.ready_OUT_DECODE    = w_ready;
  assign bus.enable_OUT_FREELIST = r_pop;
  assign bus.valid_OUT_ROB       = r_valid;
  assign bus.psrc1_OUT_ROB       = r_psrc1;
  assign bus.psrc2_OUT_ROB       = r_psrc2;
  assign bus.pdest_OUT_ROB       = r_pdest;
  assign bus.old_pdest_OUT_ROB   = r_old_pdest;
  assign bus.wdest_OUT_ROB       = r_wdest;
  assign bus.rrat_addr_OUT_RRAT  = r_idx;
  assign bus.recovering_OUT      = (r_state == ST_RECOVER);

endmodule
`default_nettype wire

// File: tb/tb_frat_rename.sv
`default_nettype none
// ============================================================================
// Module   : tb_frat_rename
// Brief    : Directed self-checking bench for the FRAT rename stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frat_rename;

  logic CLK;
  logic RESET_N;
  int   n_checks;
  int   n_errors;
  int   cnt;

  frat_rename_if #(.AW(5), .PW(6)) bus ();

  frat_rename #(.ARCH_REGS(32), .AW(5), .PW(6)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // RRAT model: entry k holds 40+k, truncated to the physical index width
  assign bus.rrat_data_IN_RRAT = 6'(40 + int'(bus.rrat_addr_OUT_RRAT));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic w);
    bus.valid_IN_DECODE = v;
    bus.src1_IN_DECODE  = s1;
    bus.src2_IN_DECODE  = s2;
    bus.dest_IN_DECODE  = d;
    bus.wdest_IN_DECODE = w;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET_N  = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus.free_register_IN_FREELIST = 6'd32;
    bus.free_valid_IN_FREELIST    = 1'b1;
    bus.ready_IN_ROB              = 1'b1;
    bus.flush_IN_ROB              = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    #1;
    check("rst_valid",  bus.valid_OUT_ROB, 0);
    check("rst_enable", bus.enable_OUT_FREELIST, 0);
    check("rst_recov",  bus.recovering_OUT, 0);
    check("rst_ready",  bus.ready_OUT_DECODE, 1);
    check("rst_pdest",  bus.pdest_OUT_ROB, 0);

    // 1: no destination
    drive(1, 3, 4, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check("t1_valid",  bus.valid_OUT_ROB, 1);
    check("t1_psrc1",  bus.psrc1_OUT_ROB, 3);
    check("t1_psrc2",  bus.psrc2_OUT_ROB, 4);
    check("t1_pdest",  bus.pdest_OUT_ROB, 0);
    check("t1_wdest",  bus.wdest_OUT_ROB, 0);
    check("t1_enable", bus.enable_OUT_FREELIST, 0);

    // 2: rename dest 5 with src1==dest
    drive(1, 5, 6, 5, 1);
    bus.free_register_IN_FREELIST = 6'd32;
    #1 check("t2_ready_pre", bus.ready_OUT_DECODE, 1);
    step();
    drive(0, 0, 0, 0, 0);
    check("t2_psrc1",  bus.psrc1_OUT_ROB, 5);
    check("t2_pdest",  bus.pdest_OUT_ROB, 32);
    check("t2_old",    bus.old_pdest_OUT_ROB, 5);
    check("t2_wdest",  bus.wdest_OUT_ROB, 1);
    check("t2_enable", bus.enable_OUT_FREELIST, 1);
    check("t2_ready_low", bus.ready_OUT_DECODE, 0);
    bus.free_register_IN_FREELIST = 6'd33;
    step();
    check("t2_enable_fall", bus.enable_OUT_FREELIST, 0);
    check("t2_ready_back",  bus.ready_OUT_DECODE, 1);
    check("t2_valid_clear", bus.valid_OUT_ROB, 0);
    drive(1, 5, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check("t2_new_map", bus.psrc1_OUT_ROB, 32);

    // 3: writes to $zero, back to back
    drive(1, 0, 0, 0, 1);
    #1 check("t3_ready", bus.ready_OUT_DECODE, 1);
    step();
    check("t3_pdest",  bus.pdest_OUT_ROB, 0);
    check("t3_wdest",  bus.wdest_OUT_ROB, 0);
    check("t3_enable", bus.enable_OUT_FREELIST, 0);
    check("t3_psrc1",  bus.psrc1_OUT_ROB, 0);
    drive(1, 0, 7, 0, 0);
    #1 check("t3_ready_b2b", bus.ready_OUT_DECODE, 1);
    step();
    drive(0, 0, 0, 0, 0);
    check("t3_b2b_valid", bus.valid_OUT_ROB, 1);
    check("t3_b2b_psrc2", bus.psrc2_OUT_ROB, 7);
    check("t3_zero_map",  bus.psrc1_OUT_ROB, 0);

    // 4: free list empty
    drive(1, 9, 10, 7, 1);
    bus.free_valid_IN_FREELIST = 1'b0;
    #1 check("t4_ready_low", bus.ready_OUT_DECODE, 0);
    step();
    check("t4_no_accept", bus.valid_OUT_ROB, 0);
    check("t4_no_pop",    bus.enable_OUT_FREELIST, 0);
    bus.free_valid_IN_FREELIST = 1'b1;
    #1 check("t4_ready_high", bus.ready_OUT_DECODE, 1);
    step();
    check("t4_pdest",  bus.pdest_OUT_ROB, 33);
    check("t4_old",    bus.old_pdest_OUT_ROB, 7);
    check("t4_enable", bus.enable_OUT_FREELIST, 1);
    bus.free_register_IN_FREELIST = 6'd34;

    // 5: ROB stall for 3 cycles
    bus.ready_IN_ROB = 1'b0;
    drive(1, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_valid", bus.valid_OUT_ROB, 1);
      check("t5_hold_pdest", bus.pdest_OUT_ROB, 33);
      check("t5_hold_psrc1", bus.psrc1_OUT_ROB, 9);
      check("t5_stall",      bus.ready_OUT_DECODE, 0);
    end
    bus.ready_IN_ROB = 1'b1;
    #1 check("t5_ready", bus.ready_OUT_DECODE, 1);
    step();
    drive(0, 0, 0, 0, 0);
    check("t5_valid", bus.valid_OUT_ROB, 1);
    check("t5_psrc1", bus.psrc1_OUT_ROB, 1);
    check("t5_psrc2", bus.psrc2_OUT_ROB, 2);
    check("t5_pdest", bus.pdest_OUT_ROB, 0);

    // 6: flush and RRAT recovery, restarted mid-walk
    step();
    bus.flush_IN_ROB = 1'b1;
    #1 check("t6_flush_ready", bus.ready_OUT_DECODE, 0);
    step();
    bus.flush_IN_ROB = 1'b0;
    check("t6_recov",  bus.recovering_OUT, 1);
    check("t6_addr0",  bus.rrat_addr_OUT_RRAT, 0);
    check("t6_valid0", bus.valid_OUT_ROB, 0);
    for (int i = 0; i < 40 && bus.rrat_addr_OUT_RRAT != 5'd10; i++) step();
    check("t6_reach10", bus.rrat_addr_OUT_RRAT, 10);
    bus.flush_IN_ROB = 1'b1;
    step();
    bus.flush_IN_ROB = 1'b0;
    check("t6_restart_recov", bus.recovering_OUT, 1);
    check("t6_restart_addr",  bus.rrat_addr_OUT_RRAT, 0);
    cnt = 0;
    for (int i = 0; i < 100 && bus.recovering_OUT; i++) begin
      cnt++;
      step();
    end
    check("t6_cycles", cnt, 32);
    check("t6_ready_after", bus.ready_OUT_DECODE, 1);
    drive(1, 5, 7, 0, 0);
    step();
    check("t6_map5", bus.psrc1_OUT_ROB, 45);
    check("t6_map7", bus.psrc2_OUT_ROB, 47);
    drive(1, 20, 9, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check("t6_map20", bus.psrc1_OUT_ROB, 60);
    check("t6_map9",  bus.psrc2_OUT_ROB, 49);

    // Reset during recovery restores the identity map
    bus.flush_IN_ROB = 1'b1;
    step();
    bus.flush_IN_ROB = 1'b0;
    repeat (5) step();
    check("t7_recov", bus.recovering_OUT, 1);
    RESET_N = 1'b0;
    #1;
    check("t7_rst_recov", bus.recovering_OUT, 0);
    check("t7_rst_addr",  bus.rrat_addr_OUT_RRAT, 0);
    step();
    RESET_N = 1'b1;
    drive(1, 5, 7, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check("t7_id5", bus.psrc1_OUT_ROB, 5);
    check("t7_id7", bus.psrc2_OUT_ROB, 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
